// File: rtl/decode_stage.sv
// decode_stage: registered MIPS R/I/J decode between fetch and execute.
// Optional build macro DECODE_MULDIV_EN makes mult/multu/div/divu/mfhi/mflo legal.
//
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   flush                 : squash held record and any instruction offered this cycle
//   in_valid/in_ready     : fetch handshake; in_insn (32b), in_pc (PC_WIDTH)
//   out_valid/out_ready   : downstream handshake on the one-entry output register
//   out_pc, out_opcode, out_rs, out_rt, out_sa, out_func : raw instruction fields
//   out_dest, out_imm     : write-back index, extended immediate
//   out_br_target, out_j_target : branch / jump targets (always computed)
//   out_reg_write ... out_illegal : control flags
module decode_stage #(
  parameter int PC_WIDTH           = 32,
  parameter bit ZERO_DEST_SUPPRESS = 1'b1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_insn,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [5:0]          out_opcode,
  output logic [4:0]          out_rs,
  output logic [4:0]          out_rt,
  output logic [4:0]          out_dest,
  output logic [4:0]          out_sa,
  output logic [5:0]          out_func,
  output logic [31:0]         out_imm,
  output logic [PC_WIDTH-1:0] out_br_target,
  output logic [PC_WIDTH-1:0] out_j_target,
  output logic                out_reg_write,
  output logic                out_mem_read,
  output logic                out_mem_write,
  output logic                out_mem_byte,
  output logic                out_mem_unsigned,
  output logic                out_alu_imm,
  output logic                out_branch,
  output logic                out_jump,
  output logic                out_illegal
);

  typedef struct packed {
    logic [PC_WIDTH-1:0] pc;
    logic [5:0]          opcode;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          dest;
    logic [4:0]          sa;
    logic [5:0]          func;
    logic [31:0]         imm;
    logic [PC_WIDTH-1:0] br_target;
    logic [PC_WIDTH-1:0] j_target;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                mem_byte;
    logic                mem_unsigned;
    logic                alu_imm;
    logic                branch;
    logic                jump;
    logic                illegal;
  } rec_t;

  rec_t rec_d, rec_q, dec;
  logic valid_d, valid_q;
  logic load;

  logic [5:0]          opcode;
  logic [4:0]          rs, rt, rd;
  logic [5:0]          func;
  logic [15:0]         imm16;
  logic [31:0]         imm_sx;
  logic [PC_WIDTH-1:0] pc4;
  logic [31:0]         pc4_w;
  logic [31:0]         j_w;
  logic                ill;

  assign opcode = in_insn[31:26];
  assign rs     = in_insn[25:21];
  assign rt     = in_insn[20:16];
  assign rd     = in_insn[15:11];
  assign func   = in_insn[5:0];
  assign imm16  = in_insn[15:0];
  assign imm_sx = {{16{imm16[15]}}, imm16};
  assign pc4    = in_pc + PC_WIDTH'(4);
  // Widen to 32 bits so the region bits [31:28] exist for any PC_WIDTH.
  assign pc4_w  = 32'(pc4);
  assign j_w    = {pc4_w[31:28], in_insn[25:0], 2'b00};

  always_comb begin
    dec           = '0;
    ill           = 1'b0;
    dec.pc        = in_pc;
    dec.opcode    = opcode;
    dec.rs        = rs;
    dec.rt        = rt;
    dec.sa        = in_insn[10:6];
    dec.func      = func;
    dec.imm       = imm_sx;
    dec.br_target = pc4 + PC_WIDTH'({imm_sx[29:0], 2'b00});
    dec.j_target  = PC_WIDTH'(j_w);
    unique case (opcode)
      6'h00: begin
        dec.dest = rd;
        unique case (func)
          6'h20, 6'h21, 6'h22, 6'h23,
          6'h2A, 6'h2B,
          6'h24, 6'h25, 6'h26, 6'h27,
          6'h00, 6'h02, 6'h03,
          6'h04, 6'h06, 6'h07: begin
            dec.reg_write = 1'b1;
          end
          6'h08: begin
            dec.jump = 1'b1;
            dec.dest = '0;
          end
          6'h09: begin
            dec.jump      = 1'b1;
            dec.reg_write = 1'b1;
          end
`ifdef DECODE_MULDIV_EN
          // HI/LO producers write no GPR; mfhi/mflo do.
          6'h18, 6'h19, 6'h1A, 6'h1B: begin
            dec.reg_write = 1'b0;
          end
          6'h10, 6'h12: begin
            dec.reg_write = 1'b1;
          end
`endif
          default: ill = 1'b1;
        endcase
      end
      6'h09, 6'h0A, 6'h0B: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.alu_imm   = 1'b1;
      end
      6'h0D, 6'h0E: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.alu_imm   = 1'b1;
        dec.imm       = {16'h0, imm16};
      end
      6'h0F: begin
        dec.dest      = rt;
        dec.reg_write = 1'b1;
        dec.alu_imm   = 1'b1;
        dec.imm       = {imm16, 16'h0};
      end
      6'h23, 6'h20, 6'h24: begin
        dec.dest         = rt;
        dec.reg_write    = 1'b1;
        dec.alu_imm      = 1'b1;
        dec.mem_read     = 1'b1;
        dec.mem_byte     = (opcode != 6'h23);
        dec.mem_unsigned = (opcode == 6'h24);
      end
      6'h2B, 6'h28: begin
        dec.alu_imm   = 1'b1;
        dec.mem_write = 1'b1;
        dec.mem_byte  = (opcode == 6'h28);
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        dec.branch = 1'b1;
      end
      6'h01: begin
        // REGIMM: only bltz (rt=0) and bgez (rt=1) are implemented.
        if (rt == 5'd0 || rt == 5'd1) dec.branch = 1'b1;
        else ill = 1'b1;
      end
      6'h02: begin
        dec.jump = 1'b1;
      end
      6'h03: begin
        dec.jump      = 1'b1;
        dec.reg_write = 1'b1;
        dec.dest      = 5'd31;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      dec.dest         = '0;
      dec.reg_write    = 1'b0;
      dec.mem_read     = 1'b0;
      dec.mem_write    = 1'b0;
      dec.mem_byte     = 1'b0;
      dec.mem_unsigned = 1'b0;
      dec.alu_imm      = 1'b0;
      dec.branch       = 1'b0;
      dec.jump         = 1'b0;
      dec.illegal      = 1'b1;
    end
    if (ZERO_DEST_SUPPRESS && dec.dest == 5'd0) dec.reg_write = 1'b0;
  end

  assign in_ready = flush | ~valid_q | out_ready;
  assign load     = in_valid & in_ready & ~flush;

  always_comb begin
    rec_d   = rec_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      rec_d   = dec;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      rec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rec_q   <= rec_d;
    end
  end

  assign out_valid        = valid_q;
  assign out_pc           = rec_q.pc;
  assign out_opcode       = rec_q.opcode;
  assign out_rs           = rec_q.rs;
  assign out_rt           = rec_q.rt;
  assign out_dest         = rec_q.dest;
  assign out_sa           = rec_q.sa;
  assign out_func         = rec_q.func;
  assign out_imm          = rec_q.imm;
  assign out_br_target    = rec_q.br_target;
  assign out_j_target     = rec_q.j_target;
  assign out_reg_write    = rec_q.reg_write;
  assign out_mem_read     = rec_q.mem_read;
  assign out_mem_write    = rec_q.mem_write;
  assign out_mem_byte     = rec_q.mem_byte;
  assign out_mem_unsigned = rec_q.mem_unsigned;
  assign out_alu_imm      = rec_q.alu_imm;
  assign out_branch       = rec_q.branch;
  assign out_jump         = rec_q.jump;
  assign out_illegal      = rec_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered MIPS decode stage between fetch and register-read/execute.
- Generalises the opcode/field splitter to full R/I/J decode:
  - immediate extension
  - destination selection
  - branch and jump target computation
  - control flags
  - illegal-instruction detection
- Valid/ready handshake on both sides, a one-entry output register, and a pipeline flush.

Parameters:
- PC_WIDTH, 32, width of PC and target buses; legal range 28..32.
- ZERO_DEST_SUPPRESS, 1, when 1 out_reg_write is forced 0 if out_dest==0.

Ports:
- clock  input  1  pipeline clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  squash held and incoming instruction
- in_valid  input  1  fetch presents insn/pc
- in_ready  output  1  stage can accept this cycle
- in_insn  input  32  instruction word
- in_pc  input  PC_WIDTH  instruction address
- out_valid  output  1  decoded record valid
- out_ready  input  1  downstream accepts record
- out_pc  output  PC_WIDTH  registered in_pc
- out_opcode  output  6  insn[31:26]
- out_rs  output  5  insn[25:21]
- out_rt  output  5  insn[20:16]
- out_dest  output  5  write-back register index
- out_sa  output  5  insn[10:6]
- out_func  output  6  insn[5:0]
- out_imm  output  32  extended immediate
- out_br_target  output  PC_WIDTH  branch target
- out_j_target  output  PC_WIDTH  jump target
- out_reg_write, out_mem_read, out_mem_write, out_mem_byte, out_mem_unsigned, out_alu_imm, out_branch, out_jump, out_illegal  output  1 each  control flags

Behaviour:
- Reset (synchronous, clock edge with reset=1): out_valid=0 and every out_* register=0. Overrides flush and handshake.
- in_ready = flush | ~out_valid | out_ready (combinational).
- Capture: at clock edge with in_valid & in_ready & ~flush, all out_* load the decode of in_insn/in_pc and out_valid<=1. Latency 1 cycle.
- Hold: out_valid & ~out_ready, no flush. All outputs stable; in_ready=0.
- Drain without refill: out_valid & out_ready & ~in_valid. out_valid<=0; data registers unchanged.
- Flush: out_valid<=0 at that edge. Input offered the same cycle is consumed and dropped. Data registers unchanged.
- Decoded R-type funct codes (opcode 00):
  - 20, 21, 22, 23 (add/addu/sub/subu)
  - 2A, 2B (slt/sltu)
  - 24, 25, 26, 27 (and/or/xor/nor)
  - 00, 02, 03, 04, 06, 07 (sll/srl/sra/sllv/srlv/srav)
  - 08 (jr), 09 (jalr)
  - 18, 19, 1A, 1B, 10, 12 (mult/multu/div/divu/mfhi/mflo): see Optional Feature
- Decoded opcodes (hex):
  - 09, 0A, 0B (addiu/slti/sltiu)
  - 0D, 0E, 0F (ori/xori/lui)
  - 23, 20, 24 (lw/lb/lbu)
  - 2B, 28 (sw/sb)
  - 04, 05, 06, 07 (beq/bne/blez/bgtz)
  - 01 with rt=0/1 (bltz/bgez)
  - 02, 03 (j/jal)
- Any other encoding: out_illegal=1.
- out_imm:
  - zero-extended for ori/xori
  - {imm16,16'h0} for lui
  - sign-extended otherwise, including R/J types
- out_dest:
  - rd for R-type
  - rt for I-type ALU ops and loads
  - 31 for jal
  - 0 for stores, branches, j, jr
- out_reg_write=1 for:
  - R-type except jr, mult, multu, div, divu
  - I-type ALU ops, loads, jal
  - subject to ZERO_DEST_SUPPRESS
- Memory flags:
  - out_mem_read: lw/lb/lbu
  - out_mem_write: sw/sb
  - out_mem_byte: lb/lbu/sb
  - out_mem_unsigned: lbu
- out_alu_imm: all I-type ALU ops, loads, stores.
- out_branch: beq/bne/blez/bgtz/bltz/bgez.
- out_jump: j/jal/jr/jalr.
- out_br_target = in_pc + 4 + (sext(imm16)<<2), truncated to PC_WIDTH; wraps modulo 2^PC_WIDTH.
- out_j_target = {(in_pc+4)[PC_WIDTH-1:28], insn[25:0], 2'b00}, low PC_WIDTH bits.
- Both targets are computed for every instruction.
- Illegal instruction:
  - out_illegal=1; raw fields are still output.
  - reg_write, mem_*, alu_imm, branch, jump all forced 0.

Optional Feature:
- Macro DECODE_MULDIV_EN.
- Defined: funct 18, 19, 1A, 1B, 10, 12 are legal. mfhi/mflo write rd; mult/div forms have out_reg_write=0.
- Undefined: those funct codes assert out_illegal=1 with all control flags 0.

Test Plan:
- Reset then idle -> out_valid=0; all outputs 0; in_ready=1.
- Send 0x00A63020 (add $6,$5,$6), pc=0x100, out_ready=1 -> next cycle out_valid=1, out_rs=5, out_rt=6, out_dest=6, out_reg_write=1, out_illegal=0.
- Send beq 0x1085FFFF, pc=0x200 -> out_branch=1, out_imm=0xFFFFFFFF, out_br_target=0x200; repeat with pc=0xFFFFFFFC and imm=1 -> out_br_target=0x4.
- Backpressure: out_ready=0 for 3 cycles after capture of lw 0x8C430010 -> in_ready=0, outputs stable, out_mem_read=1, out_dest=3, out_imm=0x10; new insn accepted the cycle out_ready rises.
- flush=1 while out_valid=1 and in_valid=1 -> next cycle out_valid=0; the offered insn never appears.
- mult 0x00850018 -> with DECODE_MULDIV_EN, out_illegal=0 and out_reg_write=0; without it, out_illegal=1 with all flags 0. Opcode 0x3F -> out_illegal=1 in both builds.
